ms_div: RTL
===========

// Module: ms_div
// PURPOSE
//   Signed sequential restoring divider for the switch/LED board flow; the inverse of the multiplier.
//   Shares the multiplier's start/ready handshake and its packed switch operand bus.
//   Takes the dividend and divisor from i_sw, runs one quotient bit per clock, and drives the quotient on the LEDs.
//   Sits beside the multiplier in the top-level demo, with the same stimulus style.
// PARAMETERS
//   W        8   operand width in bits; dividend, divisor, quotient and remainder are all W-bit two's complement
//   CNT_W    $clog2(W)+1   iteration counter width, derived; do not override
// PORTS
//   i_clk    in   1     system clock, rising edge
//   i_rst    in   1     asynchronous reset, active-low
//   i_start  in   1     level input; a rising edge requests a new division
//   i_sw     in   2*W   {dividend[W-1:0], divisor[W-1:0]}, signed
//   o_led    out  W     quotient, signed, truncated toward zero
//   o_ready  out  1     result valid; held until the next accepted start
//   o_busy   out  1     division in progress
//   o_dz     out  1     divide-by-zero flag for the current result
//   o_rem    out  W     remainder, signed; present only when DIV_REMAINDER_EN is defined
// BEHAVIOUR
//   - Reset (i_rst=0, async): state IDLE, o_led=0, o_ready=0, o_busy=0, o_dz=0, o_rem=0, start history=0.
//   - Start detection: i_start registered each clock. A start is accepted at an edge where i_start=1, the previous sample=0 and the state is IDLE or DONE.
//   - A start held high gives exactly one operation. Edges while busy are ignored and not queued.
//   - FSM: IDLE -> LOAD -> CALC -> FIX -> DONE -> (accepted start) -> LOAD.
//   - LOAD, 1 cycle:
//     - capture i_sw; record the sign of each operand; store |dividend| and |divisor| as W+1-bit unsigned values;
//     - clear o_ready and o_dz; set o_busy.
//   - CALC, exactly W cycles:
//     - shift the {partial remainder, quotient} pair left by 1;
//     - trial-subtract |divisor|; on non-negative, keep the difference and set quotient LSB to 1, else restore.
//     - The counter counts down W-1..0.
//   - FIX, 1 cycle:
//     - negate the quotient if the operand signs differ;
//     - negate the remainder if the dividend is negative;
//     - register the outputs.
//   - DONE: o_ready=1, o_busy=0; outputs stable until the next accepted start.
//   - Latency: o_ready rises W+2 clocks after the accepting edge (10 clocks for W=8).
//   - Divide by zero (divisor==0): skip the iteration and go LOAD -> FIX -> DONE.
//     - o_led = all ones (-1), o_rem = dividend, o_dz=1.
//     - Latency is 2 clocks.
//   - Overflow: -2^(W-1) / -1 wraps to o_led = -2^(W-1), remainder 0, o_dz=0.
//   - |dividend| < |divisor|: quotient 0, remainder = dividend.
//   - Reset mid-operation: immediate return to IDLE with all outputs cleared; no partial result is exposed.
//   - Inputs are sampled only in LOAD; i_sw changes during CALC have no effect.
// CONFIGURATION
//   DIV_REMAINDER_EN defined:
//     - the o_rem port exists and carries the signed remainder;
//     - the remainder is registered in FIX.
//   DIV_REMAINDER_EN undefined:
//     - the o_rem port is absent;
//     - the remainder register is removed from the output stage;
//     - the quotient path and timing are unchanged.
// TESTING (W=8, DIV_REMAINDER_EN defined)
//   1. i_rst low 2 clocks, then high; i_sw={-49,7}; i_start 0->1 -> after 10 clocks o_ready=1, o_led=-7, o_rem=0, o_dz=0.
//   2. Signs: {7,-2} -> o_led=-3, o_rem=1; {-7,2} -> o_led=-3, o_rem=-1; {-7,-7} -> o_led=1, o_rem=0.
//   3. {5,0} -> o_ready after 2 clocks, o_led=8'hFF, o_rem=5, o_dz=1; a following {7,7} -> o_led=1, o_dz=0.
//   4. {-128,-1} -> o_led=-128, o_rem=0; {3,100} -> o_led=0, o_rem=3.
//   5. i_start held high 40 clocks -> exactly one result.
//      Second 0->1 pulse while o_busy=1 -> ignored.
//      i_sw changed during CALC -> result unaffected.
//   6. Assert i_rst low at CALC cycle 4 -> o_busy=0, o_ready=0, o_led=0 asynchronously.
//      Release reset and start {7,7} -> o_led=1 after 10 clocks.

Source files
------------

// File: rtl/ms_div.sv
// Signed sequential restoring divider: one quotient bit per clock, start/ready handshake.
// Optional remainder output enabled by defining DIV_REMAINDER_EN.
module ms_div #(
    parameter  int W     = 8,
    localparam int CNT_W = $clog2(W) + 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic [2*W-1:0] i_sw,
    output logic [W-1:0]   o_led,
    output logic           o_ready,
    output logic           o_busy,
    output logic           o_dz
`ifdef DIV_REMAINDER_EN
    ,
    output logic [W-1:0]   o_rem
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [W:0]       dvs_q, dvs_d;
    logic             neg_dvd_q, neg_dvd_d;
    logic             neg_dvs_q, neg_dvs_d;
    logic             start_q;
    logic [W-1:0]     led_q, led_d;
    logic             dz_q, dz_d;
`ifdef DIV_REMAINDER_EN
    logic [W-1:0]     rem_out_q, rem_out_d;
    logic [W-1:0]     rem_src;
`endif

    logic [W-1:0] sw_dvd, sw_dvs, dvd_mag, quo_signed;
    logic [W:0]   dvs_mag, shifted, diff;
    logic         start_acc, dvs_zero, fits;

    assign sw_dvd = i_sw[2*W-1:W];
    assign sw_dvs = i_sw[W-1:0];
    // Magnitudes are unsigned, so |-2^(W-1)| still fits in W bits.
    assign dvd_mag = sw_dvd[W-1] ? (~sw_dvd + 1'b1) : sw_dvd;
    assign dvs_mag = {1'b0, (sw_dvs[W-1] ? (~sw_dvs + 1'b1) : sw_dvs)};

    assign shifted  = {rem_q, quo_q[W-1]};
    assign fits     = (shifted >= dvs_q);
    assign diff     = shifted - dvs_q;
    assign dvs_zero = (dvs_q == '0);

    assign quo_signed = (neg_dvd_q ^ neg_dvs_q) ? (~quo_q + 1'b1) : quo_q;
`ifdef DIV_REMAINDER_EN
    // With a zero divisor no iteration ran, so quo_q still holds |dividend|.
    assign rem_src = dvs_zero ? quo_q : rem_q;
`endif

    assign start_acc = i_start && !start_q &&
                       ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_dvd_d = neg_dvd_q;
        neg_dvs_d = neg_dvs_q;
        led_d     = led_q;
        dz_d      = dz_q;
`ifdef DIV_REMAINDER_EN
        rem_out_d = rem_out_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_acc) begin
                    state_d = S_LOAD;
                    dz_d    = 1'b0;
                end
            end
            S_LOAD: begin
                neg_dvd_d = sw_dvd[W-1];
                neg_dvs_d = sw_dvs[W-1];
                quo_d     = dvd_mag;
                rem_d     = '0;
                dvs_d     = dvs_mag;
                cnt_d     = CNT_W'(W - 1);
                state_d   = (sw_dvs == '0) ? S_FIX : S_CALC;
            end
            S_CALC: begin
                if (fits) begin
                    rem_d = W'(diff);
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_d = W'(shifted);
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                led_d   = dvs_zero ? '1 : quo_signed;
                dz_d    = dvs_zero;
`ifdef DIV_REMAINDER_EN
                rem_out_d = neg_dvd_q ? (~rem_src + 1'b1) : rem_src;
`endif
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
            start_q   <= 1'b0;
            led_q     <= '0;
            dz_q      <= 1'b0;
`ifdef DIV_REMAINDER_EN
            rem_out_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_dvd_q <= neg_dvd_d;
            neg_dvs_q <= neg_dvs_d;
            start_q   <= i_start;
            led_q     <= led_d;
            dz_q      <= dz_d;
`ifdef DIV_REMAINDER_EN
            rem_out_q <= rem_out_d;
`endif
        end
    end

    assign o_led   = led_q;
    assign o_dz    = dz_q;
    assign o_ready = (state_q == S_DONE);
    assign o_busy  = (state_q == S_LOAD) || (state_q == S_CALC) || (state_q == S_FIX);
`ifdef DIV_REMAINDER_EN
    assign o_rem   = rem_out_q;
`endif

endmodule
